// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter, the two core requesters and the memory.
// The arbiter attaches to the slave modport; the core/memory side uses master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_rdy;
    logic [DATA_W-1:0] i_data;

    logic              d_re;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rdy;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdy, i_data, d_rdy, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_re, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdy, i_data, d_rdy, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Build option: define ARB_RR_EN for round-robin on contention (default: data first).
//
// state  | meaning
// IDLE   | no access; arbitrate pending requests
// ACCESS | memory controls held stable for MEM_LAT cycles
// RESP   | one-cycle ready pulse to the owner
module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              owner_d;
    logic              last_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_data_q;
    logic [DATA_W-1:0] d_data_q;

    logic d_req;
    logic rr_pick_d;
    logic grant_d;

    always_comb begin
        d_req = bus.d_re | bus.d_we;
`ifdef ARB_RR_EN
        rr_pick_d = ~last_d;
`else
        // last_grant is still tracked, but fixed priority always favours data
        rr_pick_d = last_d | 1'b1;
`endif
        grant_d = d_req & (~bus.i_req | rr_pick_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            owner_d  <= 1'b0;
            last_d   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            i_data_q <= '0;
            d_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || bus.i_req) begin
                        owner_d <= grant_d;
                        we_q    <= grant_d & bus.d_we;
                        addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                        wdata_q <= grant_d ? bus.d_wdata : '0;
                        cnt     <= CNT_W'(MEM_LAT - 1);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= RESP;
                        if (!we_q) begin
                            if (owner_d) d_data_q <= bus.mem_rdata;
                            else         i_data_q <= bus.mem_rdata;
                        end
                    end
                end
                RESP: begin
                    last_d <= owner_d;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdy     = (state == RESP) & ~owner_d;
    assign bus.d_rdy     = (state == RESP) &  owner_d;
    assign bus.i_data    = i_data_q;
    assign bus.d_rdata   = d_data_q;
    assign bus.busy      = (state != IDLE);
endmodule
